// File: rtl/regfile_pc.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pc
// Description : Register bank with one synchronous write port, two
//               combinational read ports and a built-in program counter
//               register (PC_IDX) supporting increment, jump and linked
//               jump (return address saved into LINK_IDX).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_pc #(
    parameter int WIDTH    = 16,
    parameter int NREGS    = 8,
    parameter int AW       = 3,
    parameter int PC_IDX   = 7,
    parameter int LINK_IDX = 6,
    parameter int GP_RESET = 0,
    parameter int PC_RESET = 0
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             WrEn,
    input  logic [AW-1:0]    WrAddr,
    input  logic [WIDTH-1:0] WrData,
    input  logic [AW-1:0]    RdAddrA,
    output logic [WIDTH-1:0] RdDataA,
    input  logic [AW-1:0]    RdAddrB,
    output logic [WIDTH-1:0] RdDataB,
    input  logic             PcInc,
    input  logic             PcLoad,
    input  logic [WIDTH-1:0] PcTarget,
    input  logic             LinkEn,
    output logic [WIDTH-1:0] Pc
);

    localparam logic [WIDTH-1:0] c_gp_reset = WIDTH'(GP_RESET);
    localparam logic [WIDTH-1:0] c_pc_reset = WIDTH'(PC_RESET);
    localparam logic [WIDTH-1:0] c_one      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]    c_pc_addr  = AW'(PC_IDX);

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [WIDTH-1:0] w_next [NREGS];
    logic [WIDTH-1:0] w_pc_plus1;
    logic             w_link;
    logic             w_wr_pc;

    // PC+1 wraps naturally modulo 2^WIDTH; also the return address
    assign w_pc_plus1 = r_regs[PC_IDX] + c_one;
    assign w_link     = PcLoad & LinkEn;
    assign w_wr_pc    = WrEn && (WrAddr == c_pc_addr);

    // Next-state for every register: plain write first, then the link
    // overrides a colliding write, then PC priority (explicit write wins
    // over jump, jump over increment).
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            w_next[i] = r_regs[i];
            if (WrEn && (WrAddr == AW'(i))) begin
                w_next[i] = WrData;
            end
        end
        if (w_link) begin
            w_next[LINK_IDX] = w_pc_plus1;
        end
        if (!w_wr_pc) begin
            if (PcLoad) begin
                w_next[PC_IDX] = PcTarget;
            end else if (PcInc) begin
                w_next[PC_IDX] = w_pc_plus1;
            end
        end
    end

    // Register storage with asynchronous clear
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= (i == PC_IDX) ? c_pc_reset : c_gp_reset;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= w_next[i];
            end
        end
    end

    // Reads show stored contents only; no write bypass
    assign RdDataA = r_regs[RdAddrA];
    assign RdDataB = r_regs[RdAddrB];
    assign Pc      = r_regs[PC_IDX];

endmodule
`default_nettype wire

// File: tb/tb_regfile_pc.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_pc
// Description : Self-checking bench for regfile_pc: directed vector table,
//               hand-written clear/bypass sequences and randomized traffic
//               compared against a behavioural register-bank model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_pc;

    logic        Clock = 1'b0;
    logic        Clear;
    logic        WrEn;
    logic [2:0]  WrAddr;
    logic [15:0] WrData;
    logic [2:0]  RdAddrA;
    logic [15:0] RdDataA;
    logic [2:0]  RdAddrB;
    logic [15:0] RdDataB;
    logic        PcInc;
    logic        PcLoad;
    logic [15:0] PcTarget;
    logic        LinkEn;
    logic [15:0] Pc;

    regfile_pc #(
        .WIDTH(16), .NREGS(8), .AW(3), .PC_IDX(7), .LINK_IDX(6),
        .GP_RESET(0), .PC_RESET(0)
    ) dut (
        .Clock(Clock), .Clear(Clear), .WrEn(WrEn), .WrAddr(WrAddr),
        .WrData(WrData), .RdAddrA(RdAddrA), .RdDataA(RdDataA),
        .RdAddrB(RdAddrB), .RdDataB(RdDataB), .PcInc(PcInc),
        .PcLoad(PcLoad), .PcTarget(PcTarget), .LinkEn(LinkEn), .Pc(Pc)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Behavioural model: register contents as a plain array
    logic [15:0] m [8];

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic        inc;
        logic        load;
        logic [15:0] tgt;
        logic        link;
        logic [15:0] epc;
        logic [15:0] ea;
        logic [15:0] eb;
    } vec_t;

    vec_t tv [16];

    function automatic vec_t mk(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                                input logic [2:0] ra, input logic [2:0] rb, input logic inc,
                                input logic load, input logic [15:0] tgt, input logic link,
                                input logic [15:0] epc, input logic [15:0] ea, input logic [15:0] eb);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb; v.inc = inc;
        v.load = load; v.tgt = tgt; v.link = link; v.epc = epc; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m[i] = 16'h0000;
    endtask

    // Apply the architectural rules for one rising edge to the model
    task automatic model_edge();
        logic [15:0] old_pc;
        logic [15:0] nxt [8];
        old_pc = m[7];
        for (int i = 0; i < 8; i++) nxt[i] = m[i];
        if (WrEn) nxt[WrAddr] = WrData;
        if (PcLoad && LinkEn) nxt[6] = old_pc + 16'd1;
        if (!(WrEn && WrAddr == 3'd7)) begin
            if (PcLoad)     nxt[7] = PcTarget;
            else if (PcInc) nxt[7] = old_pc + 16'd1;
        end
        for (int i = 0; i < 8; i++) m[i] = nxt[i];
    endtask

    task automatic clock_edge();
        model_edge();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        WrEn = 1'b0; WrAddr = 3'd0; WrData = 16'h0; PcInc = 1'b0;
        PcLoad = 1'b0; PcTarget = 16'h0; LinkEn = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_pc"}, Pc, m[7]);
        chk({tag, "_rda"}, RdDataA, m[RdAddrA]);
        chk({tag, "_rdb"}, RdDataB, m[RdAddrB]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed table, starting from reset with reg2 = BEEF
        tv[0]  = mk(0, 0, 16'h0000, 7, 6, 1, 0, 16'h0000, 0, 16'h0001, 16'h0001, 16'h0000);
        tv[1]  = mk(1, 2, 16'h1111, 2, 7, 0, 0, 16'h0000, 0, 16'h0001, 16'h1111, 16'h0001);
        tv[2]  = mk(1, 7, 16'hFFFF, 7, 2, 0, 0, 16'h0000, 0, 16'hFFFF, 16'hFFFF, 16'h1111);
        tv[3]  = mk(0, 0, 16'h0000, 7, 6, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
        tv[4]  = mk(1, 7, 16'h0010, 7, 7, 0, 0, 16'h0000, 0, 16'h0010, 16'h0010, 16'h0010);
        tv[5]  = mk(0, 0, 16'h0000, 6, 7, 0, 1, 16'h0100, 1, 16'h0100, 16'h0011, 16'h0100);
        tv[6]  = mk(1, 6, 16'hAAAA, 6, 7, 0, 0, 16'h0000, 0, 16'h0100, 16'hAAAA, 16'h0100);
        tv[7]  = mk(1, 7, 16'h0010, 7, 6, 0, 0, 16'h0000, 0, 16'h0010, 16'h0010, 16'hAAAA);
        tv[8]  = mk(0, 0, 16'h0000, 6, 7, 0, 1, 16'h0100, 0, 16'h0100, 16'hAAAA, 16'h0100);
        tv[9]  = mk(1, 7, 16'h0040, 7, 6, 1, 1, 16'h0200, 0, 16'h0040, 16'h0040, 16'hAAAA);
        tv[10] = mk(1, 7, 16'h0005, 7, 6, 0, 0, 16'h0000, 0, 16'h0005, 16'h0005, 16'hAAAA);
        tv[11] = mk(1, 6, 16'h1234, 6, 7, 0, 1, 16'h0200, 1, 16'h0200, 16'h0006, 16'h0200);
        tv[12] = mk(0, 0, 16'h0000, 6, 7, 1, 0, 16'h0000, 1, 16'h0201, 16'h0006, 16'h0201);
        tv[13] = mk(1, 7, 16'h0300, 6, 7, 0, 1, 16'h0500, 1, 16'h0300, 16'h0202, 16'h0300);
        tv[14] = mk(1, 3, 16'h5555, 3, 7, 1, 0, 16'h0000, 0, 16'h0301, 16'h5555, 16'h0301);
        tv[15] = mk(0, 0, 16'h0000, 0, 1, 1, 0, 16'h0000, 0, 16'h0302, 16'h0000, 16'h0000);

        // Reset
        idle_inputs();
        RdAddrA = 3'd0; RdAddrB = 3'd7;
        Clear = 1'b1;
        @(posedge Clock);
        @(posedge Clock);
        #1;
        Clear = 1'b0;
        model_clear();
        chk("reset_pc", Pc, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            RdAddrA = 3'(i);
            #1;
            chk("reset_reg", RdDataA, 16'h0000);
        end

        // No write bypass: old value before the edge, new value after
        WrEn = 1'b1; WrAddr = 3'd2; WrData = 16'hBEEF; RdAddrA = 3'd2; RdAddrB = 3'd2;
        #1;
        chk("nobypass_before", RdDataA, 16'h0000);
        clock_edge();
        chk("write_after_a", RdDataA, 16'hBEEF);
        chk("write_after_b", RdDataB, 16'hBEEF);
        idle_inputs();

        // Directed vectors
        for (int i = 0; i < 16; i++) begin
            WrEn = tv[i].we; WrAddr = tv[i].wa; WrData = tv[i].wd;
            RdAddrA = tv[i].ra; RdAddrB = tv[i].rb; PcInc = tv[i].inc;
            PcLoad = tv[i].load; PcTarget = tv[i].tgt; LinkEn = tv[i].link;
            clock_edge();
            chk($sformatf("vec%0d_pc", i), Pc, tv[i].epc);
            chk($sformatf("vec%0d_rda", i), RdDataA, tv[i].ea);
            chk($sformatf("vec%0d_rdb", i), RdDataB, tv[i].eb);
        end
        idle_inputs();

        // Clear asserted across a linking jump edge: jump and link discarded
        WrEn = 1'b1; WrAddr = 3'd6; WrData = 16'h7777;
        clock_edge();
        WrAddr = 3'd7; WrData = 16'h0040;
        clock_edge();
        idle_inputs();
        PcLoad = 1'b1; PcTarget = 16'h0700; LinkEn = 1'b1;
        RdAddrA = 3'd6; RdAddrB = 3'd7;
        #2;
        Clear = 1'b1;
        @(posedge Clock);
        #1;
        idle_inputs();
        Clear = 1'b0;
        model_clear();
        chk("clear_jump_pc", Pc, 16'h0000);
        chk("clear_jump_link", RdDataA, 16'h0000);
        clock_edge();
        chk("clear_jump_hold", Pc, 16'h0000);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            WrEn     = ($urandom_range(0, 9) < 3);
            WrAddr   = 3'($urandom_range(0, 7));
            WrData   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            PcInc    = ($urandom_range(0, 1) == 1);
            PcLoad   = ($urandom_range(0, 4) == 0);
            PcTarget = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            LinkEn   = ($urandom_range(0, 1) == 1);
            RdAddrA  = 3'($urandom_range(0, 7));
            RdAddrB  = 3'($urandom_range(0, 7));
            clock_edge();
            check_model("rand");
        end
        idle_inputs();

        // Mid-cycle clear pulse with no clock edge, then count up
        WrEn = 1'b1; WrAddr = 3'd7; WrData = 16'h1234;
        clock_edge();
        WrAddr = 3'd2; WrData = 16'h5678;
        clock_edge();
        idle_inputs();
        RdAddrA = 3'd7; RdAddrB = 3'd2;
        #2;
        Clear = 1'b1;
        #1;
        chk("async_clear_pc", Pc, 16'h0000);
        chk("async_clear_rda", RdDataA, 16'h0000);
        chk("async_clear_rdb", RdDataB, 16'h0000);
        #1;
        Clear = 1'b0;
        model_clear();
        PcInc = 1'b1;
        for (int i = 0; i < 3; i++) clock_edge();
        chk("count_after_clear", Pc, 16'h0003);
        check_model("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
